// File: rtl/fft_mp_pkg.sv
// Shared types and helpers for the FFT reorder buffer.
// Size decode, bit reversal and FSM state encodings.
package fft_mp_pkg;

  localparam int DW_DEF        = 16;
  localparam int MAX_LOG2N_DEF = 11;
  localparam int MIN_LOG2N_DEF = 3;

  typedef enum logic {
    W_IDLE,
    W_FILL
  } wstate_e;

  typedef enum logic {
    R_IDLE,
    R_DRAIN
  } rstate_e;

  function automatic logic [3:0] np2log2n(
    input logic [3:0] np,
    input int         min_l,
    input int         max_l
  );
    if (int'(np) > max_l - min_l) return 4'(max_l);
    return 4'(int'(np) + min_l);
  endfunction

  function automatic logic [15:0] bitrev(
    input logic [15:0] a,
    input logic [3:0]  l
  );
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 16; i++) begin
      if (i < int'(l)) r[4'(i)] = a[4'(int'(l) - 1 - i)];
    end
    return r;
  endfunction

  function automatic logic [15:0] lastidx(input logic [3:0] l);
    return 16'((32'd1 << l) - 32'd1);
  endfunction

endpackage

// File: rtl/fft_mp_reorder_if.sv
// Sample stream bundle for the reorder buffer.
// master drives input samples and out_ready; slave is the buffer.
interface fft_mp_reorder_if
  import fft_mp_pkg::*;
#(
  parameter int DW = DW_DEF
);
  logic [3:0]    np;
  logic          bitrev_en;
  logic          in_valid;
  logic          in_ready;
  logic          in_sop;
  logic [DW-1:0] in_re;
  logic [DW-1:0] in_im;
  logic          out_valid;
  logic          out_ready;
  logic          out_sop;
  logic          out_eop;
  logic [DW-1:0] out_re;
  logic [DW-1:0] out_im;
  logic [3:0]    out_log2n;
  logic          err;

  modport master (
    output np, bitrev_en, in_valid, in_sop,
    output in_re, in_im, out_ready,
    input  in_ready, out_valid, out_sop, out_eop,
    input  out_re, out_im, out_log2n, err
  );

  modport slave (
    input  np, bitrev_en, in_valid, in_sop,
    input  in_re, in_im, out_ready,
    output in_ready, out_valid, out_sop, out_eop,
    output out_re, out_im, out_log2n, err
  );
endinterface

// File: rtl/fft_mp_bank_ram.sv
// One ping-pong bank: simple dual-port RAM.
// Single write port, registered read port that holds when idle.
module fft_mp_bank_ram #(
  parameter int AW = 11,
  parameter int W  = 32
) (
  input  logic          clk,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [W-1:0]  i_wdata,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [W-1:0]  o_rdata
);
  logic [W-1:0] r_mem [2**AW];
  logic [W-1:0] r_rdata;

  // write port and registered read port
  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;
endmodule

// File: rtl/fft_mp_reorder.sv
// Ping-pong reorder buffer: bit-reversed or natural input,
// natural-order output frames with valid/ready on both sides.
module fft_mp_reorder
  import fft_mp_pkg::*;
#(
  parameter int DW        = DW_DEF,
  parameter int MAX_LOG2N = MAX_LOG2N_DEF,
  parameter int MIN_LOG2N = MIN_LOG2N_DEF
) (
  input logic              clk,
  input logic              rst,
  fft_mp_reorder_if.slave  bus
);
  localparam int AW = MAX_LOG2N;
  localparam int W  = 2 * DW;

  wstate_e       r_wstate;
  logic          r_wbank;
  logic [AW-1:0] r_wcnt;
  rstate_e       r_rstate;
  logic          r_rbank;
  logic [AW-1:0] r_rcnt;
  logic [1:0]    r_full;
  logic [1:0]    r_brev;
  logic [3:0]    r_log2n [2];
  logic          r_s1_v, r_s1_sop, r_s1_eop, r_s1_bank;
  logic [3:0]    r_s1_log2n;
  logic          r_out_valid, r_out_sop, r_out_eop, r_err;
  logic [W-1:0]  r_out_data;
  logic [3:0]    r_out_log2n;

  logic          w_in_ready, w_accept, w_start, w_np_bad;
  logic [3:0]    w_in_log2n;
  logic          w_we, w_wlast, w_fin;
  logic [AW-1:0] w_waddr;
  logic          w_out_en, w_s1_free, w_rd_en, w_rlast, w_rdone;
  logic [3:0]    w_rlog2n;
  logic [AW-1:0] w_rcnt, w_raddr;
  logic [1:0]    w_set, w_clr;
  logic [W-1:0]  w_rdata [2];

  assign w_in_ready = !r_full[r_wbank];
  assign w_accept   = bus.in_valid && w_in_ready;
  assign w_start    = w_accept && bus.in_sop;
  assign w_np_bad   = int'(bus.np) > MAX_LOG2N - MIN_LOG2N;
  assign w_in_log2n = np2log2n(bus.np, MIN_LOG2N, MAX_LOG2N);
  assign w_we       = w_start || (w_accept && r_wstate == W_FILL);
  assign w_waddr    = w_start ? '0 : r_wcnt;
  assign w_wlast    = r_wstate == W_FILL && !bus.in_sop &&
                      r_wcnt == AW'(lastidx(r_log2n[r_wbank]));
  assign w_fin      = w_accept && w_wlast;

  assign w_out_en  = !r_out_valid || bus.out_ready;
  assign w_s1_free = !r_s1_v || w_out_en;
  assign w_rlog2n  = r_log2n[r_rbank];
  assign w_rlast   = r_rcnt == AW'(lastidx(w_rlog2n));
  assign w_rd_en   = w_s1_free &&
                     ((r_rstate == R_IDLE && r_full[r_rbank]) ||
                      r_rstate == R_DRAIN);
  assign w_rdone   = w_rd_en && r_rstate == R_DRAIN && w_rlast;
  assign w_rcnt    = (r_rstate == R_IDLE) ? '0 : r_rcnt;
  assign w_raddr   = r_brev[r_rbank] ?
                     AW'(bitrev(16'(w_rcnt), w_rlog2n)) : w_rcnt;

  assign w_set = w_fin   ? (r_wbank ? 2'b10 : 2'b01) : 2'b00;
  assign w_clr = w_rdone ? (r_rbank ? 2'b10 : 2'b01) : 2'b00;

  for (genvar b = 0; b < 2; b++) begin : g_bank
    fft_mp_bank_ram #(.AW(AW), .W(W)) u_ram (
      .clk     (clk),
      .i_we    (w_we && r_wbank == 1'(b)),
      .i_waddr (w_waddr),
      .i_wdata ({bus.in_re, bus.in_im}),
      .i_re    (w_rd_en && r_rbank == 1'(b)),
      .i_raddr (w_raddr),
      .o_rdata (w_rdata[b])
    );
  end

  // write FSM: a new sop always restarts the current bank
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wstate <= W_IDLE;
      r_wbank  <= 1'b0;
      r_wcnt   <= '0;
    end else if (w_accept) begin
      if (bus.in_sop) begin
        r_wstate <= W_FILL;
        r_wcnt   <= AW'(1);
      end else if (r_wstate == W_FILL) begin
        if (w_wlast) begin
          r_wstate <= W_IDLE;
          r_wbank  <= ~r_wbank;
          r_wcnt   <= '0;
        end else begin
          r_wcnt <= r_wcnt + 1'b1;
        end
      end
    end
  end

  // per-bank frame size and order, latched at sop
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_log2n[0] <= '0;
      r_log2n[1] <= '0;
      r_brev     <= '0;
    end else if (w_start) begin
      r_log2n[r_wbank] <= w_in_log2n;
      r_brev[r_wbank]  <= bus.bitrev_en;
    end
  end

  // full flags: write side sets, read side clears, other banks
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_full <= '0;
    else     r_full <= (r_full | w_set) & ~w_clr;
  end

  // error pulse on mid-frame sop or out-of-range size
  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_err <= 1'b0;
    else     r_err <= w_start && (w_np_bad || r_wstate == W_FILL);
  end

  // read FSM: issue one address per free pipeline slot
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rstate <= R_IDLE;
      r_rbank  <= 1'b0;
      r_rcnt   <= '0;
    end else if (w_rd_en) begin
      if (r_rstate == R_IDLE) begin
        r_rstate <= R_DRAIN;
        r_rcnt   <= AW'(1);
      end else if (w_rlast) begin
        r_rstate <= R_IDLE;
        r_rbank  <= ~r_rbank;
        r_rcnt   <= '0;
      end else begin
        r_rcnt <= r_rcnt + 1'b1;
      end
    end
  end

  // tags travelling alongside the RAM read register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1_v     <= 1'b0;
      r_s1_sop   <= 1'b0;
      r_s1_eop   <= 1'b0;
      r_s1_bank  <= 1'b0;
      r_s1_log2n <= '0;
    end else if (w_s1_free) begin
      r_s1_v     <= w_rd_en;
      r_s1_sop   <= w_rd_en && r_rstate == R_IDLE;
      r_s1_eop   <= w_rdone;
      r_s1_bank  <= r_rbank;
      r_s1_log2n <= w_rlog2n;
    end
  end

  // output register, held while downstream stalls
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid <= 1'b0;
      r_out_sop   <= 1'b0;
      r_out_eop   <= 1'b0;
      r_out_data  <= '0;
      r_out_log2n <= '0;
    end else if (w_out_en) begin
      r_out_valid <= r_s1_v;
      r_out_sop   <= r_s1_v && r_s1_sop;
      r_out_eop   <= r_s1_v && r_s1_eop;
      r_out_data  <= w_rdata[r_s1_bank];
      r_out_log2n <= r_s1_log2n;
    end
  end

  assign bus.in_ready  = w_in_ready;
  assign bus.out_valid = r_out_valid;
  assign bus.out_sop   = r_out_sop;
  assign bus.out_eop   = r_out_eop;
  assign bus.out_re    = r_out_data[W-1:DW];
  assign bus.out_im    = r_out_data[DW-1:0];
  assign bus.out_log2n = r_out_log2n;
  assign bus.err       = r_err;
endmodule

// File: tb/tb_fft_mp_reorder.sv
// Directed bench for the FFT reorder buffer.
// Each task drives one scenario and checks its own results.
module tb_fft_mp_reorder;
  localparam int DW = 16;

  typedef struct packed {
    logic        sop;
    logic        eop;
    logic [3:0]  l2;
    logic [15:0] re;
    logic [15:0] im;
    int          cyc;
  } smp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_mp_reorder_if #(.DW(DW)) bus ();

  fft_mp_reorder #(
    .DW(DW), .MAX_LOG2N(11), .MIN_LOG2N(3)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  smp_t q[$];
  int   cyc = 0, err_cnt = 0, acc_cnt = 0, last_acc = 0;
  int   checks = 0, errors = 0;

  // capture accepted outputs, err pulses and input accepts
  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (!rst && bus.out_valid && bus.out_ready)
      q.push_back({bus.out_sop, bus.out_eop, bus.out_log2n,
                   bus.out_re, bus.out_im, cyc});
    if (!rst && bus.err) err_cnt <= err_cnt + 1;
    if (!rst && bus.in_valid && bus.in_ready) begin
      acc_cnt  <= acc_cnt + 1;
      last_acc <= cyc;
    end
  end

  initial begin
    #5000000;
    $display("FAIL watchdog: simulation did not end");
    $fatal(1);
  end

  function automatic int tb_rev(input int v, input int bits);
    int r = 0;
    for (int i = 0; i < bits; i++) r = (r << 1) | ((v >> i) & 1);
    return r;
  endfunction

  function automatic logic [37:0] expv(input int k, input int n,
                                       input int l, input int base);
    logic [15:0] v;
    v = 16'(base + k);
    return {k == 0, k == n - 1, 4'(l), v, ~v};
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_sample(input logic sop, input logic [3:0] np,
                             input logic br, input logic [15:0] re,
                             output bit ok);
    int t = 0;
    bus.in_valid  = 1'b1;
    bus.in_sop    = sop;
    bus.np        = np;
    bus.bitrev_en = br;
    bus.in_re     = re;
    bus.in_im     = ~re;
    ok = 1'b0;
    while (!ok && t < 500) begin
      ok = bus.in_ready;
      tick(1);
      t++;
    end
    bus.in_valid = 1'b0;
    bus.in_sop   = 1'b0;
  endtask

  task automatic send_frame(input int l, input logic [3:0] np,
                            input logic br, input int base);
    bit ok, all_ok;
    int v;
    all_ok = 1'b1;
    for (int k = 0; k < (1 << l) && all_ok; k++) begin
      v = br ? base + tb_rev(k, l) : base + k;
      send_sample(k == 0, np, br, 16'(v), ok);
      all_ok = all_ok && ok;
    end
    checks++;
    if (!all_ok) begin
      errors++;
      $display("FAIL send base=%0d: in_ready stuck low (accepted=0, required=1)",
               base);
    end
  endtask

  task automatic wait_out(input int idx, input int n, input int budget);
    int t = 0;
    while (q.size() < idx + n && t < budget) begin
      tick(1);
      t++;
    end
    checks++;
    if (q.size() < idx + n) begin
      errors++;
      $display("FAIL wait_out: got %0d samples, required %0d",
               q.size() - idx, n);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.np = '0; bus.bitrev_en = 1'b0; bus.in_valid = 1'b0;
    bus.in_sop = 1'b0; bus.in_re = '0; bus.in_im = '0;
    bus.out_ready = 1'b0;
    tick(3);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset out_valid: got %b required 0", bus.out_valid);
    end
    checks++;
    if (bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset in_ready: got %b required 1", bus.in_ready);
    end
    checks++;
    if ({bus.out_sop, bus.out_eop, bus.out_re, bus.out_im,
         bus.out_log2n, bus.err} !== '0) begin
      errors++;
      $display("FAIL reset outputs: got %b%b %h %h %h %b required all 0",
               bus.out_sop, bus.out_eop, bus.out_re, bus.out_im,
               bus.out_log2n, bus.err);
    end
    rst = 1'b0;
    tick(2);
  endtask

  task automatic test_bitrev8();
    int i0 = q.size();
    bus.out_ready = 1'b1;
    send_frame(3, 4'd0, 1'b1, 0);
    wait_out(i0, 8, 100);
    tick(20);
    checks++;
    if (q.size() != i0 + 8) begin
      errors++;
      $display("FAIL bitrev8 count: got %0d required 8", q.size() - i0);
    end
    if (q.size() >= i0 + 8) begin
      checks++;
      if (q[i0].cyc - last_acc != 3) begin
        errors++;
        $display("FAIL bitrev8 latency: got %0d cycles required 2",
                 q[i0].cyc - last_acc - 1);
      end
      for (int i = 0; i < 8; i++) begin
        checks++;
        if ({q[i0+i].sop, q[i0+i].eop, q[i0+i].l2, q[i0+i].re,
             q[i0+i].im} !== expv(i, 8, 3, 0)) begin
          errors++;
          $display("FAIL bitrev8 sample %0d: got re=%h sop=%b eop=%b required re=%h",
                   i, q[i0+i].re, q[i0+i].sop, q[i0+i].eop, 16'(i));
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    int i0 = q.size();
    logic [37:0] e;
    bus.out_ready = 1'b1;
    send_frame(4, 4'd1, 1'b0, 100);
    send_frame(3, 4'd0, 1'b0, 200);
    wait_out(i0, 24, 200);
    if (q.size() >= i0 + 24) begin
      for (int i = 0; i < 24; i++) begin
        e = (i < 16) ? expv(i, 16, 4, 100) : expv(i - 16, 8, 3, 200);
        checks++;
        if ({q[i0+i].sop, q[i0+i].eop, q[i0+i].l2, q[i0+i].re,
             q[i0+i].im} !== e) begin
          errors++;
          $display("FAIL b2b sample %0d: got %h required %h", i,
                   {q[i0+i].sop, q[i0+i].eop, q[i0+i].l2, q[i0+i].re,
                    q[i0+i].im}, e);
        end
        if (i > 0) begin
          checks++;
          if (q[i0+i].cyc != q[i0+i-1].cyc + 1) begin
            errors++;
            $display("FAIL b2b gap at %0d: got %0d cycles required 1",
                     i, q[i0+i].cyc - q[i0+i-1].cyc);
          end
        end
      end
    end
  endtask

  task automatic test_stall_toggle();
    int i0 = q.size();
    fork
      send_frame(4, 4'd1, 1'b1, 300);
      begin
        bit          sp = 1'b0;
        logic [15:0] hr = '0, hi = '0;
        for (int c = 0; c < 80; c++) begin
          if (sp) begin
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_re !== hr ||
                bus.out_im !== hi) begin
              errors++;
              $display("FAIL stall hold c=%0d: got v=%b re=%h required v=1 re=%h",
                       c, bus.out_valid, bus.out_re, hr);
            end
          end
          bus.out_ready = c[0];
          sp = bus.out_valid && !bus.out_ready;
          hr = bus.out_re;
          hi = bus.out_im;
          tick(1);
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_out(i0, 16, 100);
    tick(10);
    checks++;
    if (q.size() != i0 + 16) begin
      errors++;
      $display("FAIL stall count: got %0d required 16", q.size() - i0);
    end
    if (q.size() >= i0 + 16) begin
      for (int i = 0; i < 16; i++) begin
        checks++;
        if ({q[i0+i].sop, q[i0+i].eop, q[i0+i].l2, q[i0+i].re,
             q[i0+i].im} !== expv(i, 16, 4, 300)) begin
          errors++;
          $display("FAIL stall sample %0d: got re=%h required re=%h",
                   i, q[i0+i].re, 16'(300 + i));
        end
      end
    end
  endtask

  task automatic test_backpressure();
    int i0 = q.size();
    int a0 = acc_cnt;
    bus.out_ready = 1'b0;
    tick(1);
    fork
      begin
        send_frame(3, 4'd0, 1'b0, 400);
        send_frame(3, 4'd0, 1'b0, 500);
        send_frame(3, 4'd0, 1'b0, 600);
      end
      begin
        tick(40);
        checks++;
        if (acc_cnt - a0 != 16) begin
          errors++;
          $display("FAIL bp accepts: got %0d required 16", acc_cnt - a0);
        end
        checks++;
        if (bus.in_ready !== 1'b0) begin
          errors++;
          $display("FAIL bp in_ready: got %b required 0", bus.in_ready);
        end
        checks++;
        if (bus.out_valid !== 1'b1 || bus.out_re !== 16'd400) begin
          errors++;
          $display("FAIL bp held out: got v=%b re=%h required v=1 re=0190",
                   bus.out_valid, bus.out_re);
        end
        bus.out_ready = 1'b1;
      end
    join
    wait_out(i0, 24, 200);
    if (q.size() >= i0 + 24) begin
      for (int i = 0; i < 24; i++) begin
        checks++;
        if ({q[i0+i].sop, q[i0+i].eop, q[i0+i].l2, q[i0+i].re,
             q[i0+i].im} !== expv(i % 8, 8, 3, 400 + 100 * (i / 8))) begin
          errors++;
          $display("FAIL bp sample %0d: got re=%h required re=%h", i,
                   q[i0+i].re, 16'(400 + 100 * (i / 8) + i % 8));
        end
      end
    end
  endtask

  task automatic test_sop_restart();
    int i0 = q.size();
    int e0 = err_cnt;
    bit ok;
    bus.out_ready = 1'b1;
    for (int k = 0; k < 5; k++) send_sample(k == 0, 4'd0, 1'b0, 16'(700 + k), ok);
    send_frame(3, 4'd0, 1'b0, 800);
    wait_out(i0, 8, 100);
    tick(20);
    checks++;
    if (err_cnt - e0 != 1) begin
      errors++;
      $display("FAIL restart err: got %0d pulses required 1", err_cnt - e0);
    end
    checks++;
    if (q.size() != i0 + 8) begin
      errors++;
      $display("FAIL restart count: got %0d required 8", q.size() - i0);
    end
    if (q.size() >= i0 + 8) begin
      for (int i = 0; i < 8; i++) begin
        checks++;
        if ({q[i0+i].sop, q[i0+i].eop, q[i0+i].l2, q[i0+i].re,
             q[i0+i].im} !== expv(i, 8, 3, 800)) begin
          errors++;
          $display("FAIL restart sample %0d: got re=%h required re=%h",
                   i, q[i0+i].re, 16'(800 + i));
        end
      end
    end
  endtask

  task automatic test_rst_mid_drain();
    int i0 = q.size();
    int i1, e0;
    bus.out_ready = 1'b1;
    send_frame(4, 4'd1, 1'b0, 900);
    wait_out(i0, 3, 50);
    rst = 1'b1;
    tick(1);
    checks++;
    if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
      errors++;
      $display("FAIL rst drain: got v=%b rdy=%b required v=0 rdy=1",
               bus.out_valid, bus.in_ready);
    end
    rst = 1'b0;
    tick(6);
    checks++;
    if (bus.out_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst banks empty: got out_valid=%b required 0",
               bus.out_valid);
    end
    e0 = err_cnt;
    i1 = q.size();
    send_frame(11, 4'd9, 1'b1, 0);
    wait_out(i1, 2048, 3000);
    tick(5);
    checks++;
    if (err_cnt - e0 != 1) begin
      errors++;
      $display("FAIL np9 err: got %0d pulses required 1", err_cnt - e0);
    end
    if (q.size() >= i1 + 2048) begin
      for (int i = 0; i < 2048; i++) begin
        checks++;
        if ({q[i1+i].sop, q[i1+i].eop, q[i1+i].l2, q[i1+i].re,
             q[i1+i].im} !== expv(i, 2048, 11, 0)) begin
          errors++;
          $display("FAIL np9 sample %0d: got re=%h l2=%0d required re=%h l2=11",
                   i, q[i1+i].re, q[i1+i].l2, 16'(i));
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_bitrev8();
    test_back_to_back();
    test_stall_toggle();
    test_backpressure();
    test_sop_restart();
    test_rst_mid_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
